// File: rtl/dct2_4pt_row_stage.sv
// First-pass 4-point DCT-II row stage: butterfly, kernel multiply, round/shift/saturate.
// Three-stage pipeline with a row counter that frames 4-row blocks for the transpose buffer.
module dct2_4pt_row_stage #(
    parameter int IN_WIDTH   = 11,
    parameter int DATA_WIDTH = 16,
    parameter int SHIFT      = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         hold,
    input  logic                         in_valid,
    input  logic signed [IN_WIDTH-1:0]   in_0,
    input  logic signed [IN_WIDTH-1:0]   in_1,
    input  logic signed [IN_WIDTH-1:0]   in_2,
    input  logic signed [IN_WIDTH-1:0]   in_3,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_0,
    output logic signed [DATA_WIDTH-1:0] out_1,
    output logic signed [DATA_WIDTH-1:0] out_2,
    output logic signed [DATA_WIDTH-1:0] out_3,
    output logic [1:0]                   row_idx,
    output logic                         block_last
);

    localparam int EW    = IN_WIDTH + 1;   // butterfly width
    localparam int PW    = IN_WIDTH + 10;  // full-precision product width
    localparam int SW    = PW + 1;         // room for the rounding add
    localparam int RND_I = (SHIFT > 0) ? (1 << (SHIFT - 1)) : 0;

    localparam logic signed [PW-1:0] K64 = PW'(64);
    localparam logic signed [PW-1:0] K83 = PW'(83);
    localparam logic signed [PW-1:0] K36 = PW'(36);
    localparam logic signed [SW-1:0] K_RND = SW'(RND_I);
    localparam logic signed [SW-1:0] K_MAX = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] K_MIN = ~K_MAX;

    // Rounding shift (floor via arithmetic shift) followed by clamp to the output range.
    function automatic logic signed [DATA_WIDTH-1:0] f_round_sat(input logic signed [PW-1:0] y);
        logic signed [SW-1:0] sum;
        logic signed [SW-1:0] shr;
        sum = $signed({y[PW-1], y}) + K_RND;
        shr = sum >>> SHIFT;
        if (shr > K_MAX) begin
            f_round_sat = K_MAX[DATA_WIDTH-1:0];
        end else if (shr < K_MIN) begin
            f_round_sat = K_MIN[DATA_WIDTH-1:0];
        end else begin
            f_round_sat = shr[DATA_WIDTH-1:0];
        end
    endfunction

    logic signed [EW-1:0] w_x0, w_x1, w_x2, w_x3;
    logic signed [EW-1:0] r_e0, r_e1, r_o0, r_o1;
    logic signed [PW-1:0] w_e0x, w_e1x, w_o0x, w_o1x;
    logic signed [PW-1:0] r_y0, r_y1, r_y2, r_y3;
    logic signed [DATA_WIDTH-1:0] r_out0, r_out1, r_out2, r_out3;
    logic       r_v1, r_v2, r_v3;
    logic [1:0] r_cnt;

    assign w_x0 = $signed({in_0[IN_WIDTH-1], in_0});
    assign w_x1 = $signed({in_1[IN_WIDTH-1], in_1});
    assign w_x2 = $signed({in_2[IN_WIDTH-1], in_2});
    assign w_x3 = $signed({in_3[IN_WIDTH-1], in_3});

    assign w_e0x = $signed({{(PW-EW){r_e0[EW-1]}}, r_e0});
    assign w_e1x = $signed({{(PW-EW){r_e1[EW-1]}}, r_e1});
    assign w_o0x = $signed({{(PW-EW){r_o0[EW-1]}}, r_o0});
    assign w_o1x = $signed({{(PW-EW){r_o1[EW-1]}}, r_o1});

    // Stage 1: even/odd butterfly; data only loads on a valid row.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_v1 <= 1'b0;
        end else if (!hold) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_e0 <= w_x0 + w_x3;
                r_e1 <= w_x1 + w_x2;
                r_o0 <= w_x0 - w_x3;
                r_o1 <= w_x1 - w_x2;
            end
        end
    end

    // Stage 2: kernel multiply at full precision.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_v2 <= 1'b0;
        end else if (!hold) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_y0 <= (w_e0x + w_e1x) * K64;
                r_y2 <= (w_e0x - w_e1x) * K64;
                r_y1 <= w_o0x * K83 + w_o1x * K36;
                r_y3 <= w_o0x * K36 - w_o1x * K83;
            end
        end
    end

    // Stage 3: round, shift and saturate into the output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_v3   <= 1'b0;
            r_out0 <= '0;
            r_out1 <= '0;
            r_out2 <= '0;
            r_out3 <= '0;
        end else if (!hold) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_out0 <= f_round_sat(r_y0);
                r_out1 <= f_round_sat(r_y1);
                r_out2 <= f_round_sat(r_y2);
                r_out3 <= f_round_sat(r_y3);
            end
        end
    end

    // Row counter advances once per row actually captured downstream.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= 2'd0;
        end else if (!hold && r_v3) begin
            r_cnt <= r_cnt + 2'd1;
        end
    end

    assign out_valid  = r_v3;
    assign out_0      = r_out0;
    assign out_1      = r_out1;
    assign out_2      = r_out2;
    assign out_3      = r_out3;
    assign row_idx    = r_cnt;
    assign block_last = r_v3 & (r_cnt == 2'd3);

endmodule

// File: tb/tb_dct2_4pt_row_stage.sv
// Scoreboard bench: two instances (SHIFT=3 and SHIFT=0) share the stimulus; expected rows come
// from an integer model of the transform and are popped by a monitor on each captured row.
module tb_dct2_4pt_row_stage;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, hold, in_valid;
    logic signed [10:0] in_0, in_1, in_2, in_3;

    logic a_ov, b_ov, a_bl, b_bl;
    logic [1:0] a_idx, b_idx;
    logic signed [15:0] a_o0, a_o1, a_o2, a_o3, b_o0, b_o1, b_o2, b_o3;
    logic [63:0] got_a, got_b;

    assign got_a = {a_o3, a_o2, a_o1, a_o0};
    assign got_b = {b_o3, b_o2, b_o1, b_o0};

    dct2_4pt_row_stage #(.IN_WIDTH(11), .DATA_WIDTH(16), .SHIFT(3)) u_dut_a (
        .clock(clock), .reset(reset), .hold(hold), .in_valid(in_valid),
        .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
        .out_valid(a_ov), .out_0(a_o0), .out_1(a_o1), .out_2(a_o2), .out_3(a_o3),
        .row_idx(a_idx), .block_last(a_bl)
    );

    dct2_4pt_row_stage #(.IN_WIDTH(11), .DATA_WIDTH(16), .SHIFT(0)) u_dut_b (
        .clock(clock), .reset(reset), .hold(hold), .in_valid(in_valid),
        .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
        .out_valid(b_ov), .out_0(b_o0), .out_1(b_o1), .out_2(b_o2), .out_3(b_o3),
        .row_idx(b_idx), .block_last(b_bl)
    );

    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    int eidx[2] = '{0, 0};
    int n_checks = 0;
    int n_fail = 0;

    // Reference transform: plain integer arithmetic, floor rounding, clamp to 16 bits.
    function automatic logic [63:0] model(input int x0, input int x1, input int x2, input int x3,
                                          input int sh);
        int y[4];
        int r;
        logic [63:0] res;
        y[0] = 64 * (x0 + x1 + x2 + x3);
        y[1] = 83 * (x0 - x3) + 36 * (x1 - x2);
        y[2] = 64 * ((x0 + x3) - (x1 + x2));
        y[3] = 36 * (x0 - x3) - 83 * (x1 - x2);
        res = '0;
        for (int i = 0; i < 4; i++) begin
            r = (y[i] + ((sh > 0) ? (1 << (sh - 1)) : 0)) >>> sh;
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
            res[16*i +: 16] = 16'(r);
        end
        return res;
    endfunction

    task automatic mon(input int d, input logic ov, input logic [63:0] got, input logic [1:0] idx,
                       input logic bl);
        logic [63:0] exp;
        int qs;
        if (reset || !ov) return;
        qs = (d == 0) ? q_a.size() : q_b.size();
        n_checks++;
        if (qs == 0) begin
            n_fail++;
            $display("FAIL unexpected_row dut%0d: got out_valid=1 data=%h, required no row", d, got);
            return;
        end
        exp = (d == 0) ? q_a[0] : q_b[0];
        if (got !== exp || idx !== 2'(eidx[d]) || bl !== (eidx[d] == 3)) begin
            n_fail++;
            $display("FAIL row dut%0d%s: got data=%h idx=%0d last=%0b, required data=%h idx=%0d last=%0b",
                     d, hold ? " held" : "", got, idx, bl, exp, eidx[d], eidx[d] == 3);
        end
        if (!hold) begin
            if (d == 0) void'(q_a.pop_front());
            else void'(q_b.pop_front());
            eidx[d] = (eidx[d] + 1) % 4;
        end
    endtask

    // Monitor: a held valid row is compared but stays at the head of the queue.
    always @(negedge clock) begin
        mon(0, a_ov, got_a, a_idx, a_bl);
        mon(1, b_ov, got_b, b_idx, b_bl);
    end

    task automatic cyc(input bit v, input bit h, input bit r, input int x0, input int x1,
                       input int x2, input int x3);
        @(posedge clock);
        #1;
        if (reset) begin
            q_a.delete();
            q_b.delete();
            eidx[0] = 0;
            eidx[1] = 0;
        end
        reset = r;
        hold = h;
        in_valid = v;
        in_0 = 11'(x0);
        in_1 = 11'(x1);
        in_2 = 11'(x2);
        in_3 = 11'(x3);
        if (v && !h && !r) begin
            q_a.push_back(model(x0, x1, x2, x3, 3));
            q_b.push_back(model(x0, x1, x2, x3, 0));
        end
    endtask

    task automatic rst_check(input string name);
        @(negedge clock);
        n_checks++;
        if (a_ov !== 1'b0 || b_ov !== 1'b0 || a_idx !== 2'd0 || b_idx !== 2'd0 || a_bl !== 1'b0 ||
            b_bl !== 1'b0 || got_a !== 64'd0 || got_b !== 64'd0) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b/%0b idx=%0d/%0d last=%0b/%0b data=%h/%h, required all 0",
                     name, a_ov, b_ov, a_idx, b_idx, a_bl, b_bl, got_a, got_b);
        end
    endtask

    function automatic int rs();
        return int'($urandom_range(0, 2047)) - 1024;
    endfunction

    task automatic rand_row(input bit h, input bit r);
        cyc(1'b1, h, r, rs(), rs(), rs(), rs());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        int h0, h1, h2, h3;
        reset = 1'b1;
        hold = 1'b0;
        in_valid = 1'b0;
        in_0 = '0;
        in_1 = '0;
        in_2 = '0;
        in_3 = '0;
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        cyc(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        rst_check("reset_state");

        // Eight back-to-back rows: DC, impulses, saturation, then random.
        cyc(1'b1, 1'b0, 1'b0, 100, 100, 100, 100);
        cyc(1'b1, 1'b0, 1'b0, 10, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, -10, 0, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1023, 1023, 1023, 1023);
        cyc(1'b1, 1'b0, 1'b0, -1024, -1024, -1024, -1024);
        for (int i = 0; i < 3; i++) rand_row(1'b0, 1'b0);
        idle(5);

        // Hold for two cycles while row 1 is presented; the input offered meanwhile is re-presented.
        for (int i = 0; i < 4; i++) rand_row(1'b0, 1'b0);
        h0 = rs();
        h1 = rs();
        h2 = rs();
        h3 = rs();
        cyc(1'b1, 1'b1, 1'b0, h0, h1, h2, h3);
        cyc(1'b1, 1'b1, 1'b0, h0, h1, h2, h3);
        cyc(1'b1, 1'b0, 1'b0, h0, h1, h2, h3);
        idle(6);

        // Reset after two rows of a block have been captured; in-flight rows are discarded.
        for (int i = 0; i < 5; i++) rand_row(1'b0, 1'b0);
        rand_row(1'b0, 1'b1);
        rand_row(1'b0, 1'b0);
        rst_check("reset_mid_block");
        idle(6);

        // Random traffic with holds, bubbles and occasional resets.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 15, $urandom_range(0, 99) == 0,
                rs(), rs(), rs(), rs());
        end

        for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) idle(1);
        idle(1);
        n_checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d rows outstanding, required 0", q_a.size(), q_b.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
